// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU, debug loader) arbiter for a single-port
// external memory. Each transaction takes IDLE -> ACCESS -> RESP -> IDLE.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : simultaneous requests alternate using a last-grant pointer
//   undefined : simultaneous requests always go to the debug loader
module mem_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_we,
  output logic              cpu_ack,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic              mem_oe,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   we_q;        // registered direction of the current transaction
  logic   grant_dbg_c; // 1 when the debug loader wins this IDLE cycle

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant; // 0 = CPU, 1 = debug; requester granted most recently

  // Winner selection: a lone requester wins, a tie goes to whoever was not last granted
  always_comb begin
    grant_dbg_c = dbg_req;
    if (cpu_req && dbg_req) begin
      grant_dbg_c = ~last_grant;
    end
  end

  // Last-grant pointer follows every grant
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if ((state == IDLE) && (cpu_req || dbg_req)) begin
      last_grant <= grant_dbg_c;
    end
  end
`else
  // Winner selection: fixed priority, debug always beats CPU
  always_comb begin
    grant_dbg_c = dbg_req;
  end
`endif

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          if (cpu_req || dbg_req) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            owner     <= grant_dbg_c;
            mem_addr  <= grant_dbg_c ? dbg_addr  : cpu_addr;
            mem_wdata <= grant_dbg_c ? dbg_wdata : cpu_wdata;
            we_q      <= grant_dbg_c ? dbg_we    : cpu_we;
            mem_we    <= grant_dbg_c ? dbg_we    : cpu_we;
            mem_oe    <= grant_dbg_c ? dbg_we    : cpu_we;
          end
        end
        ACCESS: begin
          // Read data is captured at the end of the single access cycle
          if (!we_q) begin
            rdata <= mem_rdata;
          end
          mem_we  <= 1'b0;
          mem_oe  <= 1'b0;
          cpu_ack <= ~owner;
          dbg_ack <= owner;
          state   <= RESP;
        end
        RESP: begin
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          mem_we  <= 1'b0;
          mem_oe  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Outputs are sampled on the
// falling clock edge; inputs are driven right after that sample.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_we;
  logic              cpu_ack;
  logic              dbg_ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              mem_oe;
  logic              busy;
  logic              owner;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_we    (dbg_we),
    .cpu_ack   (cpu_ack),
    .dbg_ack   (dbg_ack),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .busy      (busy),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset and check every output against its reset value
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_ack, dbg_ack, mem_we, mem_oe, busy, owner} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: acks/we/oe/busy/owner=%b expected 000000",
               {cpu_ack, dbg_ack, mem_we, mem_oe, busy, owner});
    end
    checks++;
    if (rdata !== 8'h00 || mem_addr !== 4'h0 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h expected 00/0/00",
               rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  // CPU read of address 3 returning 0xA5
  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_addr = 4'h3; cpu_we = 1'b0; cpu_wdata = 8'h00;
    mem_rdata = 8'hA5;
    @(negedge clk); // ACCESS
    checks++;
    if (busy !== 1'b1 || mem_we !== 1'b0 || mem_oe !== 1'b0 || mem_addr !== 4'h3 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_access: busy=%b we=%b oe=%b addr=%h ack=%b expected 1 0 0 3 0",
               busy, mem_we, mem_oe, mem_addr, cpu_ack);
    end
    @(negedge clk); // RESP
    checks++;
    if (cpu_ack !== 1'b1 || dbg_ack !== 1'b0 || rdata !== 8'hA5 || owner !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_resp: cpu_ack=%b dbg_ack=%b rdata=%h owner=%b expected 1 0 a5 0",
               cpu_ack, dbg_ack, rdata, owner);
    end
    cpu_req = 1'b0;
    @(negedge clk); // IDLE
    checks++;
    if (cpu_ack !== 1'b0 || busy !== 1'b0 || rdata !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_read_idle: ack=%b busy=%b rdata=%h expected 0 0 a5", cpu_ack, busy, rdata);
    end
  endtask

  // Debug write 0x3C to address 0xF; rdata must not change
  task automatic test_dbg_write();
    dbg_req = 1'b1; dbg_addr = 4'hF; dbg_wdata = 8'h3C; dbg_we = 1'b1;
    mem_rdata = 8'h77;
    @(negedge clk); // ACCESS
    checks++;
    if (mem_addr !== 4'hF || mem_wdata !== 8'h3C || mem_we !== 1'b1 || mem_oe !== 1'b1 || owner !== 1'b1) begin
      errors++;
      $display("FAIL dbg_write_access: addr=%h wdata=%h we=%b oe=%b owner=%b expected f 3c 1 1 1",
               mem_addr, mem_wdata, mem_we, mem_oe, owner);
    end
    @(negedge clk); // RESP
    checks++;
    if (dbg_ack !== 1'b1 || cpu_ack !== 1'b0 || mem_we !== 1'b0 || mem_oe !== 1'b0 || rdata !== 8'hA5) begin
      errors++;
      $display("FAIL dbg_write_resp: dbg_ack=%b cpu_ack=%b we=%b oe=%b rdata=%h expected 1 0 0 0 a5",
               dbg_ack, cpu_ack, mem_we, mem_oe, rdata);
    end
    dbg_req = 1'b0;
    @(negedge clk); // IDLE
    checks++;
    if (mem_we !== 1'b0 || dbg_ack !== 1'b0 || mem_addr !== 4'hF || mem_wdata !== 8'h3C) begin
      errors++;
      $display("FAIL dbg_write_idle: we=%b ack=%b addr=%h wdata=%h expected 0 0 f 3c",
               mem_we, dbg_ack, mem_addr, mem_wdata);
    end
  endtask

  // Both requesters held for four transactions starting from reset
  task automatic test_arbitration();
    logic exp_dbg [4];
    logic got_ack;
    int   wait_n;
`ifdef ARB_ROUND_ROBIN_EN
    exp_dbg = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_dbg = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cpu_req = 1'b1; cpu_addr = 4'h1; cpu_we = 1'b0;
    dbg_req = 1'b1; dbg_addr = 4'h2; dbg_we = 1'b0;
    mem_rdata = 8'h11;
    for (int t = 0; t < 4; t++) begin
      got_ack = 1'b0;
      wait_n  = 0;
      while (!got_ack && wait_n < 4) begin
        @(negedge clk);
        wait_n++;
        checks++;
        if (cpu_ack === 1'b1 && dbg_ack === 1'b1) begin
          errors++;
          $display("FAIL arb_both_acks: txn=%0d cpu_ack=%b dbg_ack=%b expected never both",
                   t, cpu_ack, dbg_ack);
        end
        if (cpu_ack === 1'b1 || dbg_ack === 1'b1) got_ack = 1'b1;
      end
      checks++;
      if (!got_ack) begin
        errors++;
        $display("FAIL arb_timeout: txn=%0d no ack within 4 cycles", t);
      end else if (dbg_ack !== exp_dbg[t] || cpu_ack !== ~exp_dbg[t] || owner !== exp_dbg[t]) begin
        errors++;
        $display("FAIL arb_grant: txn=%0d dbg_ack=%b cpu_ack=%b owner=%b expected dbg=%b",
                 t, dbg_ack, cpu_ack, owner, exp_dbg[t]);
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk); // IDLE
  endtask

  // Reset hitting the ACCESS cycle of a write aborts it
  task automatic test_reset_abort();
    dbg_req = 1'b1; dbg_addr = 4'h5; dbg_wdata = 8'h99; dbg_we = 1'b1;
    @(negedge clk); // ACCESS
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 4'h5) begin
      errors++;
      $display("FAIL abort_access: we=%b addr=%h expected 1 5", mem_we, mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_ack, dbg_ack, mem_we, mem_oe, busy, owner} !== 6'b0 ||
        rdata !== 8'h00 || mem_addr !== 4'h0 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL abort_reset: ctrl=%b rdata=%h addr=%h wdata=%h expected 000000 00 0 00",
               {cpu_ack, dbg_ack, mem_we, mem_oe, busy, owner}, rdata, mem_addr, mem_wdata);
    end
    @(negedge clk); // request still held while in reset
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_req_in_reset: busy=%b we=%b ack=%b expected 0 0 0", busy, mem_we, dbg_ack);
    end
    rst = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dbg_ack !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: busy=%b ack=%b we=%b expected 0 0 0", busy, dbg_ack, mem_we);
    end
  endtask

  // CPU request held continuously: one transaction every 3 cycles
  task automatic test_back_to_back();
    int busy_low;
    logic exp_busy;
    logic exp_ack;
    logic [ADDR_W-1:0] exp_addr;
    busy_low = 0;
    cpu_req = 1'b1; cpu_addr = 4'h6; cpu_we = 1'b0;
    mem_rdata = 8'h5A;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      exp_busy = ((k % 3) != 2);
      exp_ack  = ((k % 3) == 1);
      exp_addr = (k < 3) ? 4'h6 : 4'h9;
      if (busy === 1'b0) busy_low++;
      checks++;
      if (busy !== exp_busy || cpu_ack !== exp_ack || dbg_ack !== 1'b0 || mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL b2b_cycle%0d: busy=%b cpu_ack=%b dbg_ack=%b addr=%h expected %b %b 0 %h",
                 k, busy, cpu_ack, dbg_ack, mem_addr, exp_busy, exp_ack, exp_addr);
      end
      if (k == 1) begin
        checks++;
        if (rdata !== 8'h5A) begin
          errors++;
          $display("FAIL b2b_rdata: rdata=%h expected 5a", rdata);
        end
      end
      if (k == 0) cpu_addr = 4'h9; // change mid-ACCESS; picked up next IDLE only
    end
    checks++;
    if (busy_low != 3) begin
      errors++;
      $display("FAIL b2b_busy_low: count=%0d expected 3", busy_low);
    end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    dbg_req = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_we = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_arbitration();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
